// File: rtl/pipeline_hazard_controller.sv
// MIPS pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, interlocks and redirect.
// Latency: pc/flush controls combinational in ID; ex_*/mem_*/wb_* appear 1/2/3 cycles after decode.
// Backpressure: a stall holds PC and IF/ID and injects a bubble into ID/EX; later stages always advance.
module pipeline_hazard_controller #(
    parameter int                    OPCODE_W  = 6,
    parameter int                    RA_W      = 5,
    parameter int                    LINK_REG  = 31,
    parameter bit                    EN_HAZARD = 1'b1,
    parameter logic [OPCODE_W-1:0]   OP_RTYPE  = OPCODE_W'(0),
    parameter logic [OPCODE_W-1:0]   OP_ADDI   = OPCODE_W'(1),
    parameter logic [OPCODE_W-1:0]   OP_SLTI   = OPCODE_W'(2),
    parameter logic [OPCODE_W-1:0]   OP_LW     = OPCODE_W'(3),
    parameter logic [OPCODE_W-1:0]   OP_SW     = OPCODE_W'(4),
    parameter logic [OPCODE_W-1:0]   OP_BEQ    = OPCODE_W'(5),
    parameter logic [OPCODE_W-1:0]   OP_J      = OPCODE_W'(6),
    parameter logic [OPCODE_W-1:0]   OP_JR     = OPCODE_W'(7),
    parameter logic [OPCODE_W-1:0]   OP_JAL    = OPCODE_W'(8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                equal,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_flush,
    output logic [1:0]          pc_src,
    output logic [1:0]          ex_alu_op,
    output logic [1:0]          ex_alu_src,
    output logic                ex_link,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [RA_W-1:0]     wb_dst,
    output logic                illegal_op
);

    typedef struct packed {
        logic [1:0]      alu_op;
        logic [1:0]      alu_src;
        logic            link;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } id_ex_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } mem_wb_t;

    id_ex_t  dec;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic known;
    logic uses_rs;
    logic uses_rt;
    logic is_beq;
    logic is_jr;
    logic is_jump;
    logic load_use;
    logic br_ex_dep;
    logic br_mem_dep;
    logic stall;

    always_comb begin
        dec     = '0;
        known   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_jr   = 1'b0;
        is_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.alu_op    = 2'b10;
                dec.dst       = id_rd;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 2'b01;
                dec.dst       = id_rt;
                dec.reg_write = 1'b1;
            end
            OP_SLTI: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 2'b01;
                dec.dst       = id_rt;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 2'b01;
                dec.dst        = id_rt;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 2'b01;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op = 2'b01;
                uses_rt    = 1'b1;
                is_beq     = 1'b1;
            end
            OP_J: begin
                uses_rs = 1'b0;
                is_jump = 1'b1;
            end
            OP_JR: begin
                is_jr = 1'b1;
            end
            OP_JAL: begin
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
                dec.dst       = RA_W'(LINK_REG);
                uses_rs       = 1'b0;
                is_jump       = 1'b1;
            end
            default: begin
                known = 1'b0;
            end
        endcase
        // $0 is hardwired, so a write to it is dropped here rather than in the datapath
        if (dec.dst == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    always_comb begin
        load_use   = id_ex.mem_read && (id_ex.dst != '0) &&
                     ((uses_rs && (id_ex.dst == id_rs)) || (uses_rt && (id_ex.dst == id_rt)));
        br_ex_dep  = (is_beq || is_jr) && id_ex.reg_write &&
                     ((uses_rs && (id_ex.dst == id_rs)) || (uses_rt && (id_ex.dst == id_rt)));
        br_mem_dep = (is_beq || is_jr) && ex_mem.mem_read &&
                     ((uses_rs && (ex_mem.dst == id_rs)) || (uses_rt && (ex_mem.dst == id_rt)));
        stall      = EN_HAZARD && (load_use || br_ex_dep || br_mem_dep);
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        pc_src      = 2'b00;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_flush    = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (is_beq && equal) begin
            pc_src   = 2'b01;
            if_flush = 1'b1;
        end else if (is_jump) begin
            pc_src   = 2'b10;
            if_flush = 1'b1;
        end else if (is_jr) begin
            pc_src   = 2'b11;
            if_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex      <= '0;
            ex_mem     <= '0;
            mem_wb     <= '0;
            illegal_op <= 1'b0;
        end else begin
            id_ex  <= stall ? '0 : dec;
            ex_mem <= '{mem_read:   id_ex.mem_read,
                        mem_write:  id_ex.mem_write,
                        reg_write:  id_ex.reg_write,
                        mem_to_reg: id_ex.mem_to_reg,
                        dst:        id_ex.dst};
            mem_wb <= '{reg_write:  ex_mem.reg_write,
                        mem_to_reg: ex_mem.mem_to_reg,
                        dst:        ex_mem.dst};
            if (!known) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign ex_alu_op     = id_ex.alu_op;
    assign ex_alu_src    = id_ex.alu_src;
    assign ex_link       = id_ex.link;
    assign mem_read      = ex_mem.mem_read;
    assign mem_write     = ex_mem.mem_write;
    assign wb_reg_write  = mem_wb.reg_write;
    assign wb_mem_to_reg = mem_wb.mem_to_reg;
    assign wb_dst        = mem_wb.dst;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: hazard-enabled and software-scheduled instances share stimulus,
// both compared each cycle against a stage-queue reference model.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       equal;

    logic       pw[2], iw[2], fl[2], lk[2], mr[2], mw[2], wrw[2], wm2r[2], ill[2];
    logic [1:0] ps[2], aop[2], asrc[2];
    logic [4:0] wd[2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.EN_HAZARD(1'b1)) u_hz (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .equal(equal), .pc_write(pw[0]), .if_id_write(iw[0]), .if_flush(fl[0]), .pc_src(ps[0]),
        .ex_alu_op(aop[0]), .ex_alu_src(asrc[0]), .ex_link(lk[0]), .mem_read(mr[0]),
        .mem_write(mw[0]), .wb_reg_write(wrw[0]), .wb_mem_to_reg(wm2r[0]), .wb_dst(wd[0]),
        .illegal_op(ill[0]));

    pipeline_hazard_controller #(.EN_HAZARD(1'b0)) u_nohz (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .equal(equal), .pc_write(pw[1]), .if_id_write(iw[1]), .if_flush(fl[1]), .pc_src(ps[1]),
        .ex_alu_op(aop[1]), .ex_alu_src(asrc[1]), .ex_link(lk[1]), .mem_read(mr[1]),
        .mem_write(mw[1]), .wb_reg_write(wrw[1]), .wb_mem_to_reg(wm2r[1]), .wb_dst(wd[1]),
        .illegal_op(ill[1]));

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src;
        logic       link;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       m2r;
        logic [4:0] dst;
    } mb_t;

    // Per instance: index 0 hazard-enabled, index 1 software-scheduled
    mb_t  m_ex[2], m_mem[2], m_wb[2];
    logic m_ill[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mb_t m_dec(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        mb_t b = '0;
        case (op)
            6'd0: begin b.alu_op = 2'b10; b.dst = rd; b.rw = 1'b1; end
            6'd1: begin b.alu_src = 2'b01; b.dst = rt; b.rw = 1'b1; end
            6'd2: begin b.alu_op = 2'b11; b.alu_src = 2'b01; b.dst = rt; b.rw = 1'b1; end
            6'd3: begin b.alu_src = 2'b01; b.dst = rt; b.rw = 1'b1; b.mrd = 1'b1; b.m2r = 1'b1; end
            6'd4: begin b.alu_src = 2'b01; b.mwr = 1'b1; end
            6'd5: b.alu_op = 2'b01;
            6'd8: begin b.link = 1'b1; b.rw = 1'b1; b.dst = 5'd31; end
            default: b = '0;
        endcase
        if (b.dst == 5'd0) b.rw = 1'b0;
        return b;
    endfunction

    function automatic logic m_hit(input logic [4:0] d);
        logic urs = !(opcode == 6'd6 || opcode == 6'd8);
        logic urt = (opcode == 6'd0 || opcode == 6'd4 || opcode == 6'd5);
        return (urs && d == id_rs) || (urt && d == id_rt);
    endfunction

    function automatic logic m_stall(input int h);
        logic br = (opcode == 6'd5 || opcode == 6'd7);
        if (h != 0) return 1'b0;
        return (m_ex[h].mrd && m_ex[h].dst != 5'd0 && m_hit(m_ex[h].dst)) ||
               (br && m_ex[h].rw && m_hit(m_ex[h].dst)) ||
               (br && m_mem[h].mrd && m_hit(m_mem[h].dst));
    endfunction

    // {pc_write, if_id_write, if_flush, pc_src}
    function automatic logic [4:0] m_ctrl(input int h);
        if (!rst_n)                     return 5'b00100;
        if (m_stall(h))                 return 5'b00000;
        if (opcode == 6'd5 && equal)    return 5'b11101;
        if (opcode == 6'd6 || opcode == 6'd8) return 5'b11110;
        if (opcode == 6'd7)             return 5'b11111;
        return 5'b11000;
    endfunction

    task automatic check_all();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("i%0d_ctrl", h), 32'({pw[h], iw[h], fl[h], ps[h]}), 32'(m_ctrl(h)));
            chk($sformatf("i%0d_ex", h), 32'({aop[h], asrc[h], lk[h]}),
                32'({m_ex[h].alu_op, m_ex[h].alu_src, m_ex[h].link}));
            chk($sformatf("i%0d_mem", h), 32'({mr[h], mw[h]}), 32'({m_mem[h].mrd, m_mem[h].mwr}));
            chk($sformatf("i%0d_wb", h), 32'({wrw[h], wm2r[h], wd[h]}),
                32'({m_wb[h].rw, m_wb[h].m2r, m_wb[h].dst}));
            chk($sformatf("i%0d_ill", h), 32'(ill[h]), 32'(m_ill[h]));
        end
    endtask

    task automatic tick();
        logic kn = (opcode <= 6'd8);
        for (int h = 0; h < 2; h++) begin
            logic st = m_stall(h);
            if (!rst_n) begin
                m_ex[h] = '0; m_mem[h] = '0; m_wb[h] = '0; m_ill[h] = 1'b0;
            end else begin
                m_wb[h]  = m_mem[h];
                m_mem[h] = m_ex[h];
                m_ex[h]  = (st || !kn) ? '0 : m_dec(opcode, id_rt, id_rd);
                if (!kn) m_ill[h] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic eq);
        rst_n = r; opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; equal = eq;
        #4;
        check_all();
    endtask

    task automatic cyc(input logic r, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic eq);
        drive(r, op, rs, rt, rd, eq);
        tick();
    endtask

    task automatic nop();
        cyc(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0; equal = 1'b0;
        @(posedge clk);
        #1;
        tick();
        // Reset: second reset cycle, registers now known
        drive(1'b0, 6'd3, 5'd1, 5'd2, 5'd3, 1'b1);
        chk("rst_flush", 32'(fl[0]), 32'd1);
        chk("rst_pc_write", 32'(pw[0]), 32'd0);
        chk("rst_ill", 32'(ill[0]), 32'd0);
        tick();
        nop();

        // lw $2,0($1); add $3,$2,$4
        cyc(1'b1, 6'd3, 5'd1, 5'd2, 5'd0, 1'b0);
        drive(1'b1, 6'd0, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_stall_pw", 32'(pw[0]), 32'd0);
        chk("nohz_pw", 32'(pw[1]), 32'd1);
        tick();
        cyc(1'b1, 6'd0, 5'd2, 5'd4, 5'd3, 1'b0);
        nop();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("nohz_add_wb", 32'({wrw[1], wd[1]}), 32'({1'b1, 5'd3}));
        tick();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lu_add_wb", 32'({wrw[0], wd[0]}), 32'({1'b1, 5'd3}));
        tick();
        nop();

        // lw $5; beq $5,$6 -> two stall cycles then taken
        cyc(1'b1, 6'd3, 5'd1, 5'd5, 5'd0, 1'b0);
        drive(1'b1, 6'd5, 5'd5, 5'd6, 5'd0, 1'b1);
        chk("lb_stall1", 32'(pw[0]), 32'd0);
        tick();
        drive(1'b1, 6'd5, 5'd5, 5'd6, 5'd0, 1'b1);
        chk("lb_stall2", 32'(pw[0]), 32'd0);
        tick();
        drive(1'b1, 6'd5, 5'd5, 5'd6, 5'd0, 1'b1);
        chk("lb_taken", 32'({fl[0], ps[0]}), 32'({1'b1, 2'b01}));
        tick();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lb_flush_once", 32'(fl[0]), 32'd0);
        tick();
        nop(); nop();

        // jal then jr $31
        drive(1'b1, 6'd8, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("jal_redirect", 32'({fl[0], ps[0]}), 32'({1'b1, 2'b10}));
        tick();
        nop(); nop();
        drive(1'b1, 6'd7, 5'd31, 5'd0, 5'd0, 1'b0);
        chk("jal_wb", 32'({wrw[0], wd[0]}), 32'({1'b1, 5'd31}));
        chk("jr_redirect", 32'({pw[0], fl[0], ps[0]}), 32'({1'b1, 1'b1, 2'b11}));
        tick();
        nop();

        // addi $0,$0,5 never writes
        cyc(1'b1, 6'd1, 5'd0, 5'd0, 5'd0, 1'b0);
        nop(); nop();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("addi_r0_wb", 32'(wrw[0]), 32'd0);
        tick();

        // Illegal opcode is sticky until reset
        cyc(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0);
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ill_set", 32'(ill[0]), 32'd1);
        tick();
        nop(); nop(); nop();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ill_hold", 32'(ill[0]), 32'd1);
        tick();
        cyc(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ill_clear", 32'(ill[0]), 32'd0);
        tick();

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 93)      op = 6'($urandom_range(0, 8));
            else if (sel < 96) op = 6'h3F;
            else               op = 6'($urandom_range(9, 62));
            cyc(($urandom_range(0, 99) != 0), op, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
